// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the MEM pipeline stage.
// Holds the FSM state enum, RV32I load/store funct3 encodings and the MEM/WB
// register layout together with its bubble helper.
package mem_stage_pkg;

    typedef enum logic {
        StIdle,
        StWait
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] mem_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
        logic        misalign;
    } memwb_t;

    localparam memwb_t MEMWB_RESET = '0;

    // A bubble keeps the data fields but kills every writeback side effect.
    function automatic memwb_t bubble(input memwb_t cur);
        memwb_t b;
        b            = cur;
        b.reg_write  = 1'b0;
        b.mem_to_reg = 1'b0;
        b.misalign   = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: DEPTH x 32-bit data memory with per-byte write enables,
// synchronous write and combinational (asynchronous) read.
module dmem_ram #(
    parameter int unsigned  DEPTH  = 256,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between EX/MEM and MEM/WB. Performs the data
// memory access with MEM_LATENCY optional wait cycles, stalling upstream while
// an access is outstanding. Misaligned accesses are suppressed and flagged.
// Build option: DMEM_BYTE_EN enables RV32I byte/halfword loads and stores;
// without it every access is a 32-bit word and funct3 is ignored.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned  DEPTH       = 256,
    parameter int unsigned  MEM_LATENCY = 0,
    localparam int unsigned ADDR_W      = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_out_exmem,
    input  logic [31:0] store_data_exmem,
    input  logic [4:0]  rd_exmem,
    input  logic [2:0]  funct3_exmem,
    input  logic        reg_write_exmem,
    input  logic        mem_read_exmem,
    input  logic        mem_write_exmem,
    input  logic        mem_to_reg_exmem,
    output logic        stall_mem,
    output logic [31:0] alu_out_memwb,
    output logic [31:0] mem_data_memwb,
    output logic [4:0]  rd_memwb,
    output logic        reg_write_memwb,
    output logic        mem_to_reg_memwb,
    output logic        misalign_memwb
);

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    logic              mem_acc;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] word_idx;
    logic              misalign;
    logic [3:0]        be;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [31:0]       load_data;
    logic              complete;
    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    memwb_t            memwb_q, memwb_d;

    assign mem_acc  = mem_read_exmem | mem_write_exmem;
    assign lane     = alu_out_exmem[1:0];
    assign word_idx = alu_out_exmem[ADDR_W+1:2];

`ifdef DMEM_BYTE_EN
    logic        st_byte, st_half, ld_byte, ld_half, acc_byte, acc_half;
    logic [31:0] ld_shift;
    logic        unused_addr;
    assign unused_addr = ^alu_out_exmem[31:ADDR_W+2];

    // Size decode, misalignment, store lane replication and load extension.
    always_comb begin
        st_byte  = funct3_exmem == F3_SB;
        st_half  = funct3_exmem == F3_SH;
        ld_byte  = (funct3_exmem == F3_LB) || (funct3_exmem == F3_LBU);
        ld_half  = (funct3_exmem == F3_LH) || (funct3_exmem == F3_LHU);
        // A combined read+write is a store, so store decoding wins.
        acc_byte = mem_write_exmem ? st_byte : ld_byte;
        acc_half = mem_write_exmem ? st_half : ld_half;
        misalign = acc_half ? lane[0] : (acc_byte ? 1'b0 : (lane != 2'b00));
        if (st_byte) begin
            be        = 4'b0001 << lane;
            ram_wdata = {4{store_data_exmem[7:0]}};
        end else if (st_half) begin
            be        = lane[1] ? 4'b1100 : 4'b0011;
            ram_wdata = {2{store_data_exmem[15:0]}};
        end else begin
            be        = 4'hF;
            ram_wdata = store_data_exmem;
        end
        ld_shift = ram_rdata >> {lane, 3'b000};
        if (ld_byte) begin
            load_data = (funct3_exmem == F3_LBU) ? {24'h0, ld_shift[7:0]}
                                                 : {{24{ld_shift[7]}}, ld_shift[7:0]};
        end else if (ld_half) begin
            load_data = (funct3_exmem == F3_LHU) ? {16'h0, ld_shift[15:0]}
                                                 : {{16{ld_shift[15]}}, ld_shift[15:0]};
        end else begin
            load_data = ram_rdata;
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{funct3_exmem, alu_out_exmem[31:ADDR_W+2]};
    assign misalign    = lane != 2'b00;
    assign be          = 4'hF;
    assign ram_wdata   = store_data_exmem;
    assign load_data   = ram_rdata;
`endif

    // Wait-state FSM: stall while the access is outstanding, release one
    // cycle early so upstream advances on the completing edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_mem = 1'b0;
        complete  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_acc && (MEM_LATENCY != 0)) begin
                    state_d   = StWait;
                    cnt_d     = LAT;
                    stall_mem = 1'b1;
                end else begin
                    complete = 1'b1;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d  = StIdle;
                    complete = 1'b1;
                end else begin
                    stall_mem = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset aborts the write; misaligned stores never reach the RAM.
    assign ram_be = (complete && mem_write_exmem && !misalign && !rst) ? be : 4'b0000;

    dmem_ram #(
        .DEPTH(DEPTH)
    ) u_dmem_ram (
        .clk  (clk),
        .addr (word_idx),
        .be   (ram_be),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // MEM/WB next value: latch the slot on completion, otherwise a bubble.
    always_comb begin
        memwb_d            = MEMWB_RESET;
        memwb_d.alu_out    = alu_out_exmem;
        memwb_d.mem_data   = load_data;
        memwb_d.rd         = rd_exmem;
        memwb_d.reg_write  = reg_write_exmem & ~(mem_acc & misalign);
        memwb_d.mem_to_reg = mem_to_reg_exmem;
        memwb_d.misalign   = mem_acc & misalign;
        if (!complete) begin
            memwb_d = bubble(memwb_q);
        end
    end

    // State, wait counter and MEM/WB register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            memwb_q <= MEMWB_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            memwb_q <= memwb_d;
        end
    end

    assign alu_out_memwb    = memwb_q.alu_out;
    assign mem_data_memwb   = memwb_q.mem_data;
    assign rd_memwb         = memwb_q.rd;
    assign reg_write_memwb  = memwb_q.reg_write;
    assign mem_to_reg_memwb = memwb_q.mem_to_reg;
    assign misalign_memwb   = memwb_q.misalign;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage. dut0 runs with no wait
// states (table-driven), dut3 with three wait states (hand-written sequences).
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
    } in_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        mis;
        logic        chk_data;
    } exp_t;

    typedef struct packed {
        logic        stall;
        logic [31:0] alu;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        mis;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        exp_t  e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst3;
    in_t  in0, in3;
    out_t out0, out3;

    logic        stall0, stall3, rw0, rw3, m2r0, m2r3, mis0, mis3;
    logic [31:0] alu0, alu3, data0, data3;
    logic [4:0]  rdo0, rdo3;

    assign out0 = {stall0, alu0, data0, rdo0, rw0, m2r0, mis0};
    assign out3 = {stall3, alu3, data3, rdo3, rw3, m2r3, mis3};

    mem_stage #(.DEPTH(256), .MEM_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst0),
        .alu_out_exmem(in0.alu), .store_data_exmem(in0.sd), .rd_exmem(in0.rd),
        .funct3_exmem(in0.f3), .reg_write_exmem(in0.rw), .mem_read_exmem(in0.mr),
        .mem_write_exmem(in0.mw), .mem_to_reg_exmem(in0.m2r),
        .stall_mem(stall0), .alu_out_memwb(alu0), .mem_data_memwb(data0), .rd_memwb(rdo0),
        .reg_write_memwb(rw0), .mem_to_reg_memwb(m2r0), .misalign_memwb(mis0)
    );

    mem_stage #(.DEPTH(256), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst3),
        .alu_out_exmem(in3.alu), .store_data_exmem(in3.sd), .rd_exmem(in3.rd),
        .funct3_exmem(in3.f3), .reg_write_exmem(in3.rw), .mem_read_exmem(in3.mr),
        .mem_write_exmem(in3.mw), .mem_to_reg_exmem(in3.m2r),
        .stall_mem(stall3), .alu_out_memwb(alu3), .mem_data_memwb(data3), .rd_memwb(rdo3),
        .reg_write_memwb(rw3), .mem_to_reg_memwb(m2r3), .misalign_memwb(mis3)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb[$];
    vec_t tbl[$];

    function automatic in_t mk_in(input logic [31:0] alu, input logic [31:0] sd,
                                  input logic [4:0] rd, input logic [2:0] f3, input logic rw,
                                  input logic mr, input logic mw, input logic m2r);
        in_t v;
        v = '{alu: alu, sd: sd, rd: rd, f3: f3, rw: rw, mr: mr, mw: mw, m2r: m2r};
        return v;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] alu, input logic [31:0] data,
                                    input logic [4:0] rd, input logic rw, input logic m2r,
                                    input logic mis, input logic chk_data);
        exp_t e;
        e = '{alu: alu, data: data, rd: rd, rw: rw, m2r: m2r, mis: mis, chk_data: chk_data};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cmp(input string tag, input out_t o, input exp_t e);
        chk({tag, ".alu_out"}, o.alu, e.alu);
        chk({tag, ".rd"}, 32'(o.rd), 32'(e.rd));
        chk({tag, ".reg_write"}, 32'(o.rw), 32'(e.rw));
        chk({tag, ".mem_to_reg"}, 32'(o.m2r), 32'(e.m2r));
        chk({tag, ".misalign"}, 32'(o.mis), 32'(e.mis));
        if (e.chk_data) chk({tag, ".mem_data"}, o.data, e.data);
    endtask

    // Zero-latency slot: stall must stay low, result appears one edge later.
    task automatic apply0(input string tag, input in_t v, input exp_t e);
        in0 = v;
        sb.push_back(e);
        @(negedge clk);
        chk({tag, ".stall"}, 32'(out0.stall), 32'd0);
        @(posedge clk);
        #1;
        cmp(tag, out0, sb.pop_front());
    endtask

    // Wait-state slot: bubbles while stalled, result on the first unstalled edge.
    task automatic apply3(input string tag, input in_t v, input exp_t e, input int exp_stall);
        int stalls = 0;
        bit done   = 1'b0;
        in3 = v;
        sb.push_back(e);
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (out3.stall) begin
                stalls++;
                @(posedge clk);
                #1;
                chk({tag, ".bubble"}, {29'd0, out3.rw, out3.m2r, out3.mis}, 32'd0);
            end else begin
                @(posedge clk);
                #1;
                cmp(tag, out3, sb.pop_front());
                done = 1'b1;
            end
        end
        chk({tag, ".completed"}, 32'(done), 32'd1);
        chk({tag, ".stall_cycles"}, stalls, exp_stall);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        in_t nop;
        nop  = mk_in(32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        in0  = nop;
        in3  = nop;
        rst0 = 1'b1;
        rst3 = 1'b1;

        tbl.push_back('{"sw10", mk_in(32'h10, 32'hDEADBEEF, 0, F3_SW, 0, 0, 1, 0),
                        mk_exp(32'h10, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{"lw10", mk_in(32'h10, 0, 10, F3_LW, 1, 1, 0, 1),
                        mk_exp(32'h10, 32'hDEADBEEF, 10, 1, 1, 0, 1)});
        tbl.push_back('{"alu", mk_in(32'h12345678, 0, 5, 3'd0, 1, 0, 0, 0),
                        mk_exp(32'h12345678, 0, 5, 1, 0, 0, 0)});
        tbl.push_back('{"lw13_mis", mk_in(32'h13, 0, 7, F3_LW, 1, 1, 0, 1),
                        mk_exp(32'h13, 0, 7, 0, 1, 1, 0)});
        tbl.push_back('{"lw10_b", mk_in(32'h10, 0, 8, F3_LW, 1, 1, 0, 1),
                        mk_exp(32'h10, 32'hDEADBEEF, 8, 1, 1, 0, 1)});
        tbl.push_back('{"sw12_mis", mk_in(32'h12, 32'h11111111, 0, F3_SW, 0, 0, 1, 0),
                        mk_exp(32'h12, 0, 0, 0, 0, 1, 0)});
        tbl.push_back('{"lw10_c", mk_in(32'h10, 0, 9, F3_LW, 1, 1, 0, 1),
                        mk_exp(32'h10, 32'hDEADBEEF, 9, 1, 1, 0, 1)});
        tbl.push_back('{"sw14", mk_in(32'h14, 32'h0BADF00D, 0, F3_SW, 0, 0, 1, 0),
                        mk_exp(32'h14, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{"rdwr14", mk_in(32'h14, 32'h55AA55AA, 11, F3_SW, 1, 1, 1, 1),
                        mk_exp(32'h14, 32'h0BADF00D, 11, 1, 1, 0, 1)});
        tbl.push_back('{"lw14", mk_in(32'h14, 0, 12, F3_LW, 1, 1, 0, 1),
                        mk_exp(32'h14, 32'h55AA55AA, 12, 1, 1, 0, 1)});
        tbl.push_back('{"lw_wrap", mk_in(32'h410, 0, 13, F3_LW, 1, 1, 0, 1),
                        mk_exp(32'h410, 32'hDEADBEEF, 13, 1, 1, 0, 1)});
        tbl.push_back('{"alu_odd", mk_in(32'hFFFF0003, 0, 31, 3'd0, 1, 0, 0, 0),
                        mk_exp(32'hFFFF0003, 0, 31, 1, 0, 0, 0)});

        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst3 = 1'b0;
        cmp("reset0", out0, mk_exp(0, 0, 0, 0, 0, 0, 1));
        chk("reset0.stall", 32'(out0.stall), 32'd0);
        cmp("reset3", out3, mk_exp(0, 0, 0, 0, 0, 0, 1));
        chk("reset3.stall", 32'(out3.stall), 32'd0);

        foreach (tbl[i]) apply0(tbl[i].name, tbl[i].in, tbl[i].e);

`ifdef DMEM_BYTE_EN
        apply0("sb11", mk_in(32'h11, 32'h00000080, 0, F3_SB, 0, 0, 1, 0),
               mk_exp(32'h11, 0, 0, 0, 0, 0, 0));
        apply0("lb11", mk_in(32'h11, 0, 14, F3_LB, 1, 1, 0, 1),
               mk_exp(32'h11, 32'hFFFFFF80, 14, 1, 1, 0, 1));
        apply0("lbu11", mk_in(32'h11, 0, 15, F3_LBU, 1, 1, 0, 1),
               mk_exp(32'h11, 32'h00000080, 15, 1, 1, 0, 1));
        apply0("lw10_sb", mk_in(32'h10, 0, 16, F3_LW, 1, 1, 0, 1),
               mk_exp(32'h10, 32'hDEAD80EF, 16, 1, 1, 0, 1));
`endif
        in0 = nop;

        // Three wait states: each access stalls 3 cycles then completes.
        apply3("w_sw10", mk_in(32'h10, 32'hDEADBEEF, 3, F3_SW, 0, 0, 1, 0),
               mk_exp(32'h10, 0, 3, 0, 0, 0, 0), 3);
        apply3("w_lw10", mk_in(32'h10, 0, 10, F3_LW, 1, 1, 0, 1),
               mk_exp(32'h10, 32'hDEADBEEF, 10, 1, 1, 0, 1), 3);
        apply3("w_alu", mk_in(32'h12345678, 0, 5, 3'd0, 1, 0, 0, 0),
               mk_exp(32'h12345678, 0, 5, 1, 0, 0, 0), 0);
        apply3("w_lw13_mis", mk_in(32'h13, 0, 7, F3_LW, 1, 1, 0, 1),
               mk_exp(32'h13, 0, 7, 0, 1, 1, 0), 3);
        apply3("w_sw12_mis", mk_in(32'h12, 32'h11111111, 3, F3_SW, 0, 0, 1, 0),
               mk_exp(32'h12, 0, 3, 0, 0, 1, 0), 3);
        apply3("w_lw10_b", mk_in(32'h10, 0, 8, F3_LW, 1, 1, 0, 1),
               mk_exp(32'h10, 32'hDEADBEEF, 8, 1, 1, 0, 1), 3);
        apply3("w_sw20", mk_in(32'h20, 32'h01234567, 3, F3_SW, 0, 0, 1, 0),
               mk_exp(32'h20, 0, 3, 0, 0, 0, 0), 3);

        // Reset in the second WAIT cycle aborts the store to 0x20.
        in3 = mk_in(32'h20, 32'hCAFEF00D, 3, F3_SW, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst3 = 1'b1;
        @(negedge clk);
        chk("rst_wait.stall_before", 32'(out3.stall), 32'd1);
        @(posedge clk);
        #1;
        rst3 = 1'b0;
        in3  = nop;
        cmp("rst_wait.outputs", out3, mk_exp(0, 0, 0, 0, 0, 0, 1));
        @(negedge clk);
        chk("rst_wait.stall_after", 32'(out3.stall), 32'd0);
        @(posedge clk);
        #1;
        apply3("w_lw20", mk_in(32'h20, 0, 12, F3_LW, 1, 1, 0, 1),
               mk_exp(32'h20, 32'h01234567, 12, 1, 1, 0, 1), 3);
        in3 = nop;

        chk("scoreboard.empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage directly downstream of the EX/MEM register.
- Consumes the EX/MEM outputs, performs the data-memory access on an internal word-organised RAM, and registers the result into MEM/WB outputs for writeback.
- Models configurable memory wait states and raises a stall so that IF through EX/MEM freeze while an access is outstanding.

Parameters:
- DEPTH, 256: data memory depth in 32-bit words; power of two.
- MEM_LATENCY, 0: extra wait cycles per load/store; range 0..15.
- ADDR_W, $clog2(DEPTH): derived word-index width; not overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- alu_out_exmem  input  32  effective address, or ALU result for non-memory ops.
- store_data_exmem  input  32  store data.
- rd_exmem  input  5  destination register.
- funct3_exmem  input  3  access size/sign; used only with DMEM_BYTE_EN.
- reg_write_exmem  input  1  register write enable.
- mem_read_exmem  input  1  load.
- mem_write_exmem  input  1  store.
- mem_to_reg_exmem  input  1  writeback selects memory data.
- stall_mem  output  1  hold all upstream stages.
- alu_out_memwb  output  32  registered ALU result.
- mem_data_memwb  output  32  registered load data.
- rd_memwb  output  5  registered destination register.
- reg_write_memwb  output  1  registered write enable.
- mem_to_reg_memwb  output  1  registered writeback select.
- misalign_memwb  output  1  registered flag: the access in this slot was misaligned and suppressed.

Behaviour:
- Reset:
  - All *_memwb outputs go to 0; stall_mem goes to 0; FSM goes to IDLE; wait counter goes to 0.
  - RAM contents are not cleared.
- Word index is alu_out_exmem[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- Memory access: mem_read_exmem | mem_write_exmem.
  - If both are set, the store is performed and the load is ignored. Data is written, and mem_data_memwb still captures the pre-write word.
- FSM IDLE:
  - Non-memory op, or MEM_LATENCY=0: at each edge, latch inputs into MEM/WB.
  - A store writes RAM at the same edge.
  - Load data is read combinationally from RAM and latched into mem_data_memwb. Load-to-writeback latency is 1 cycle.
  - A memory access with MEM_LATENCY>0 moves to WAIT and loads counter = MEM_LATENCY. stall_mem is asserted combinationally in this same cycle.
- FSM WAIT:
  - stall_mem=1; upstream holds EX/MEM stable. Counter decrements once per cycle.
  - Each WAIT edge writes a bubble into MEM/WB: reg_write_memwb=0, mem_to_reg_memwb=0, misalign_memwb=0, other fields unchanged.
  - When counter==1: stall_mem=0 that cycle. The access completes at the next edge (write, or read latch) and the FSM returns to IDLE.
  - Total occupancy is MEM_LATENCY+1 cycles.
- Misaligned access:
  - Without DMEM_BYTE_EN: addr[1:0]!=0.
  - With DMEM_BYTE_EN: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - The access takes the normal timing, including WAIT. No RAM write occurs; reg_write_memwb=0 and misalign_memwb=1 for that slot.
- Non-memory ops pass alu_out, rd, reg_write and mem_to_reg through with 1-cycle latency. mem_data_memwb is don't-care; the bench must not check it.
- Reset during WAIT: the access is aborted, no RAM write occurs, stall_mem drops in the next cycle, and all outputs return to reset values.

Optional Feature:
- Macro DMEM_BYTE_EN.
- Defined: funct3_exmem is decoded per RV32I.
  - Stores: SB/SH/SW write byte lanes selected by addr[1:0].
  - Loads: LB/LH sign-extend, LBU/LHU zero-extend, LW full word. Lane selected by addr[1:0].
  - Undefined funct3 values are treated as word accesses.
- Undefined: funct3_exmem is ignored; all accesses are 32-bit words.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, WAIT).
  - funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW).
  - Bubble value.
- Sub-module dmem_ram: DEPTH x 32 array with 4-bit byte write enable, synchronous write and combinational read. mem_stage holds the FSM, lane alignment/extension and the MEM/WB register.

Test Plan:
1. Reset, then with MEM_LATENCY=0 store 0xDEADBEEF to 0x10, then load 0x10 with rd=10, mem_to_reg=1 -> next cycle mem_data_memwb=0xDEADBEEF, rd_memwb=10, reg_write_memwb=1, stall_mem never 1.
2. Non-memory op alu_out=0x12345678, rd=5, reg_write=1 -> one edge later alu_out_memwb=0x12345678, rd_memwb=5, reg_write_memwb=1.
3. MEM_LATENCY=3, load from 0x10 -> stall_mem high for 3 cycles, 3 bubbles with reg_write_memwb=0, then data 0xDEADBEEF on the 4th edge.
4. Load from 0x13 -> misalign_memwb=1, reg_write_memwb=0; then load 0x10 still returns 0xDEADBEEF. Store to 0x12 -> RAM unchanged.
5. MEM_LATENCY=3, store 0xCAFEF00D to 0x20, assert rst in the 2nd WAIT cycle -> outputs zero, stall_mem=0 after reset; load 0x20 returns the old contents.
6. With DMEM_BYTE_EN: SB 0x80 to 0x11 over 0xDEADBEEF at 0x10, then LB 0x11 -> 0xFFFFFF80, LBU 0x11 -> 0x00000080, LW 0x10 -> 0xDEAD80EF.
